// File: rtl/sram_1rw_arb_ctrl.sv
// Read/write arbiter and sequencer for a single-port 1RW SRAM macro with per-lane write mask.
// Optional post-reset zero-fill sweep is enabled by defining SRAM_ARB_CTRL_INIT_EN.
module sram_1rw_arb_ctrl #(
    parameter  int ADDR_W     = 10,
    parameter  int LANES      = 16,
    parameter  int LANE_W     = 132,
    parameter  int STARVE_MAX = 4,
    localparam int DATA_W     = LANES * LANE_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r_req_valid,
    output logic              r_req_ready,
    input  logic [ADDR_W-1:0] r_req_addr,
    output logic              r_resp_valid,
    output logic [DATA_W-1:0] r_resp_data,
    input  logic              w_req_valid,
    output logic              w_req_ready,
    input  logic [ADDR_W-1:0] w_req_addr,
    input  logic [LANES-1:0]  w_req_mask,
    input  logic [DATA_W-1:0] w_req_data,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [LANES-1:0]  sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

`ifdef SRAM_ARB_CTRL_INIT_EN
    localparam int     DEPTH       = 2 ** ADDR_W;
    localparam state_t RESET_STATE = ST_INIT;
`else
    localparam state_t RESET_STATE = ST_RUN;
`endif

    state_t            state_reg;
    logic [3:0]        starve_cnt_reg;
    logic              resp_valid_reg;
    logic [DATA_W-1:0] resp_hold_reg;
    logic              run_active;
    logic              init_active;
    logic              rd_grant;
    logic              wr_grant;

`ifdef SRAM_ARB_CTRL_INIT_EN
    logic [ADDR_W-1:0] init_addr_reg;
`endif

    // Grants are masked while reset is high so nothing reaches the macro during reset.
    always_comb begin
        run_active = (state_reg == ST_RUN) && !reset;
`ifdef SRAM_ARB_CTRL_INIT_EN
        init_active = (state_reg == ST_INIT) && !reset;
`else
        init_active = 1'b0;
`endif
        wr_grant = run_active && w_req_valid &&
                   (!r_req_valid || (starve_cnt_reg < 4'(STARVE_MAX)));
        rd_grant = run_active && r_req_valid && !wr_grant;
    end

    always_comb begin
        sram_en    = rd_grant || wr_grant || init_active;
        sram_wmode = wr_grant || init_active;
        sram_addr  = wr_grant ? w_req_addr : r_req_addr;
`ifdef SRAM_ARB_CTRL_INIT_EN
        if (init_active) begin
            sram_addr = init_addr_reg;
        end
`endif
    end

    // The sweep forces every lane enabled with zero data; otherwise the write payload passes through.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign sram_wmask[gi] = init_active || w_req_mask[gi];
            assign sram_wdata[gi*LANE_W +: LANE_W] =
                init_active ? {LANE_W{1'b0}} : w_req_data[gi*LANE_W +: LANE_W];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= RESET_STATE;
            starve_cnt_reg <= 4'd0;
            resp_valid_reg <= 1'b0;
            resp_hold_reg  <= '0;
`ifdef SRAM_ARB_CTRL_INIT_EN
            init_addr_reg  <= '0;
`endif
        end else begin
            resp_valid_reg <= rd_grant;
            if (resp_valid_reg) begin
                resp_hold_reg <= sram_rdata;
            end

            // Counts writes that overtook a waiting read; any read grant or idle read side clears it.
            if (!r_req_valid || rd_grant) begin
                starve_cnt_reg <= 4'd0;
            end else if (wr_grant) begin
                starve_cnt_reg <= starve_cnt_reg + 4'd1;
            end

`ifdef SRAM_ARB_CTRL_INIT_EN
            if (state_reg == ST_INIT) begin
                init_addr_reg <= init_addr_reg + 1'b1;
                if (init_addr_reg == ADDR_W'(DEPTH - 1)) begin
                    state_reg <= ST_RUN;
                end
            end
`endif
        end
    end

    assign r_req_ready  = rd_grant;
    assign w_req_ready  = wr_grant;
    assign r_resp_valid = resp_valid_reg && !reset;
    // Bypass shows macro data during the pulse; the register keeps it afterwards.
    assign r_resp_data  = r_resp_valid ? sram_rdata : resp_hold_reg;

`ifdef SRAM_ARB_CTRL_INIT_EN
    assign init_done = (state_reg == ST_RUN);
`else
    assign init_done = 1'b1;
`endif

endmodule

// File: tb/tb_sram_1rw_arb_ctrl.sv
// Directed bench for sram_1rw_arb_ctrl: behavioural macro, reference memory and response scoreboard.
module tb_sram_1rw_arb_ctrl;

    localparam int ADDR_W     = 10;
    localparam int LANES      = 16;
    localparam int LANE_W     = 132;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 1 << ADDR_W;
    localparam int DATA_W     = LANES * LANE_W;

`ifdef SRAM_ARB_CTRL_INIT_EN
    localparam logic INIT_DONE_RST = 1'b0;
`else
    localparam logic INIT_DONE_RST = 1'b1;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              r_req_valid = 1'b0;
    logic              r_req_ready;
    logic [ADDR_W-1:0] r_req_addr = '0;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_data;
    logic              w_req_valid = 1'b0;
    logic              w_req_ready;
    logic [ADDR_W-1:0] w_req_addr = '0;
    logic [LANES-1:0]  w_req_mask = '0;
    logic [DATA_W-1:0] w_req_data = '0;
    logic              init_done;
    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [LANES-1:0]  sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    int vectors     = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] smem    [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] exp_q   [$];
    logic              rd_pending = 1'b0;
    logic              rd_granted = 1'b0;
    logic              wr_granted = 1'b0;
    logic [DATA_W-1:0] last_data  = '0;

    sram_1rw_arb_ctrl #(
        .ADDR_W(ADDR_W), .LANES(LANES), .LANE_W(LANE_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clock(clock), .reset(reset),
        .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req_addr(r_req_addr),
        .r_resp_valid(r_resp_valid), .r_resp_data(r_resp_data),
        .w_req_valid(w_req_valid), .w_req_ready(w_req_ready), .w_req_addr(w_req_addr),
        .w_req_mask(w_req_mask), .w_req_data(w_req_data),
        .init_done(init_done),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clock = ~clock;

    // Behavioural 1RW macro with registered read.
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                for (int l = 0; l < LANES; l++) begin
                    if (sram_wmask[l]) smem[sram_addr][l*LANE_W +: LANE_W] <= sram_wdata[l*LANE_W +: LANE_W];
                end
            end else begin
                sram_rdata <= smem[sram_addr];
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        logic [LANES-1:0] diff;
        for (int l = 0; l < LANES; l++) diff[l] = (obs[l*LANE_W +: LANE_W] !== exp[l*LANE_W +: LANE_W]);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed low %h required low %h lanes differing %h", tag, obs[63:0], exp[63:0], diff);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    // One cycle: sample at the falling edge, score responses, record grants, realign after the rising edge.
    task automatic step();
        logic [DATA_W-1:0] e;
        @(negedge clock);
        chk("resp_valid", 64'(r_resp_valid), 64'(rd_pending));
        if (r_resp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_data("resp_data", r_resp_data, e);
            last_data = e;
        end else if (!r_resp_valid) begin
            chk_data("resp_hold", r_resp_data, last_data);
        end
        rd_pending = 1'b0;
        chk("ready_without_req", {62'd0, r_req_ready & ~r_req_valid, w_req_ready & ~w_req_valid}, 64'd0);
        rd_granted = r_req_valid && r_req_ready;
        wr_granted = w_req_valid && w_req_ready;
        if (wr_granted) begin
            chk("wr_drive", {sram_en, sram_wmode, sram_wmask, sram_addr}, {1'b1, 1'b1, w_req_mask, w_req_addr});
            for (int l = 0; l < LANES; l++) begin
                if (w_req_mask[l]) ref_mem[w_req_addr][l*LANE_W +: LANE_W] = w_req_data[l*LANE_W +: LANE_W];
            end
        end
        if (rd_granted) begin
            chk("rd_drive", {sram_en, sram_wmode, sram_addr}, {1'b1, 1'b0, r_req_addr});
            exp_q.push_back(ref_mem[r_req_addr]);
            rd_pending = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [LANES-1:0] m, input logic [DATA_W-1:0] d);
        int n = 0;
        w_req_valid = 1'b1; w_req_addr = a; w_req_mask = m; w_req_data = d;
        wr_granted = 1'b0;
        while (!wr_granted && n < 20) begin step(); n++; end
        chk("wr_wait", 64'(wr_granted), 64'd1);
        w_req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        int n = 0;
        r_req_valid = 1'b1; r_req_addr = a;
        rd_granted = 1'b0;
        while (!rd_granted && n < 20) begin step(); n++; end
        chk("rd_wait", 64'(rd_granted), 64'd1);
        r_req_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; r_req_valid = 1'b0; w_req_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        r_req_valid = 1'b1; w_req_valid = 1'b1;
        @(negedge clock);
        chk("rst_ready", {62'd0, r_req_ready, w_req_ready}, 64'd0);
        chk("rst_resp_valid", 64'(r_resp_valid), 64'd0);
        chk_data("rst_resp_data", r_resp_data, '0);
        chk("rst_sram_en", {62'd0, sram_en, sram_wmode}, 64'd0);
        chk("rst_init_done", 64'(init_done), 64'(INIT_DONE_RST));
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete(); rd_pending = 1'b0; last_data = '0;
`ifdef SRAM_ARB_CTRL_INIT_EN
        // Requests stay raised through the sweep; no ready may appear until it completes.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            chk("init_sweep", {sram_en, sram_wmode, init_done, r_req_ready, w_req_ready, sram_wmask, sram_addr},
                {5'b11000, {LANES{1'b1}}, ADDR_W'(i)});
            chk("init_wdata", 64'(sram_wdata === '0), 64'd1);
        end
        @(posedge clock); #1;
        r_req_valid = 1'b0; w_req_valid = 1'b0;
        @(negedge clock);
        chk("init_done_rise", 64'(init_done), 64'd1);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        @(posedge clock); #1;
`else
        r_req_valid = 1'b0; w_req_valid = 1'b0;
`endif
    endtask

    initial begin
        logic [DATA_W-1:0] pat_a, pat_b, pat_c, pat_d;
        logic [DATA_W-1:0] partial_exp;
        logic              exp_w;
        int                n;
        pat_a = rand_data(); pat_b = rand_data(); pat_c = rand_data(); pat_d = rand_data();

        do_reset();
`ifdef SRAM_ARB_CTRL_INIT_EN
        do_read(10'h155);
        repeat (2) step();
        chk_data("init_zero", last_data, '0);
`endif

        // Write then read, with hold after the pulse.
        do_write(10'h155, 16'hFFFF, pat_a);
        do_read(10'h155);
        repeat (3) step();
        chk_data("wr_rd_a", last_data, pat_a);

        // Partial lane mask over prior contents at the top address.
        do_write(10'h3FF, 16'hFFFF, pat_a);
        do_write(10'h3FF, 16'h0001, pat_b);
        do_read(10'h3FF);
        repeat (2) step();
        partial_exp = {pat_a[DATA_W-1:LANE_W], pat_b[LANE_W-1:0]};
        chk_data("partial_mask", last_data, partial_exp);

        // Read immediately after write to the same address; later write must not disturb held data.
        do_write(10'h155, 16'hFFFF, pat_c);
        do_read(10'h155);
        step();
        do_write(10'h155, 16'hFFFF, pat_d);
        repeat (2) step();
        chk_data("raw_hold", r_resp_data, pat_c);

        // Back-to-back reads.
        do_write(10'h000, 16'hFFFF, rand_data());
        do_write(10'h001, 16'hFFFF, rand_data());
        do_write(10'h002, 16'hFFFF, rand_data());
        for (int i = 0; i < 3; i++) begin
            r_req_valid = 1'b1; r_req_addr = ADDR_W'(i);
            step();
            chk("b2b_grant", 64'(rd_granted), 64'd1);
        end
        r_req_valid = 1'b0;
        repeat (3) step();

        // Contention: both requesters held valid; expect W,W,W,W,R repeating.
        r_req_valid = 1'b1; r_req_addr = 10'h155;
        w_req_valid = 1'b1; w_req_addr = 10'h200; w_req_mask = 16'hFFFF; w_req_data = pat_b;
        for (int c = 0; c < 15; c++) begin
            step();
            exp_w = ((c % (STARVE_MAX + 1)) != STARVE_MAX);
            chk("arb_w", 64'(wr_granted), 64'(exp_w));
            chk("arb_r", 64'(rd_granted), 64'(!exp_w));
        end
        r_req_valid = 1'b0; w_req_valid = 1'b0;
        repeat (3) step();

        // Reset in the cycle after a read grant drops the response.
        r_req_valid = 1'b1; r_req_addr = 10'h001;
        n = 0; rd_granted = 1'b0;
        while (!rd_granted && n < 20) begin step(); n++; end
        chk("rst_mid_grant", 64'(rd_granted), 64'd1);
        r_req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_drop", 64'(r_resp_valid), 64'd0);
        @(posedge clock); #1;
        do_reset();
        repeat (2) step();

        // Traffic resumes after reset.
        do_read(10'h155);
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_1rw_arb_ctrl.md
Name: sram_1rw_arb_ctrl

Overview:
- Sequences one single-port 1RW SRAM macro: 1024 entries x 2112 bits, 16 lanes of 132 bits, per-lane write mask, 1-cycle registered read.
- Shares the macro between one read requester and one write requester (valid/ready each), with starvation-bounded write priority.
- Returns read data with a one-cycle valid pulse and holds it stable afterwards.
- Optionally zero-fills the array after reset before accepting traffic.

Parameters:
- ADDR_W, 10, macro address width; DEPTH = 2**ADDR_W
- LANES, 16, write-mask lanes
- LANE_W, 132, bits per lane; DATA_W = LANES*LANE_W = 2112
- STARVE_MAX, 4, max consecutive write grants while a read is pending; range 1..15

Ports:
- clock  in  1  sole clock; also drives macro RW0_clk
- reset  in  1  synchronous, active-high
- r_req_valid  in  1  read request
- r_req_ready  out  1  read accepted this cycle
- r_req_addr  in  ADDR_W  read address
- r_resp_valid  out  1  one-cycle pulse, read data valid
- r_resp_data  out  DATA_W  read data; stable until next pulse
- w_req_valid  in  1  write request
- w_req_ready  out  1  write accepted this cycle
- w_req_addr  in  ADDR_W  write address
- w_req_mask  in  LANES  per-lane write enable
- w_req_data  in  DATA_W  write data
- init_done  out  1  high once the controller accepts traffic
- sram_en  out  1  to macro RW0_en
- sram_wmode  out  1  to macro RW0_wmode; 1 = write
- sram_addr  out  ADDR_W  to macro RW0_addr
- sram_wmask  out  LANES  to macro RW0_wmask
- sram_wdata  out  DATA_W  to macro RW0_wdata
- sram_rdata  in  DATA_W  from macro RW0_rdata

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Reset values: r_req_ready=0, w_req_ready=0, r_resp_valid=0, r_resp_data=0, sram_en=0, sram_wmode=0, starve_cnt=0, init_done=0 (feature on) or 1 (feature off).
- FSM states: INIT and RUN.
  - Reset enters INIT with the feature on, otherwise RUN.
  - INIT -> RUN in the cycle after the sweep issues address DEPTH-1.
- Macro drive is combinational from the grant.
  - A grant sets sram_en=1.
  - Read grant: sram_wmode=0, sram_addr=r_req_addr.
  - Write grant: sram_wmode=1, sram_addr=w_req_addr, sram_wmask=w_req_mask, sram_wdata=w_req_data.
  - No grant: sram_en=0; other macro outputs are don't-care.
- Arbitration in RUN, at most one grant per cycle:
  - Only read valid -> read granted.
  - Only write valid -> write granted.
  - Both valid and starve_cnt < STARVE_MAX -> write granted; starve_cnt increments.
  - Both valid and starve_cnt == STARVE_MAX -> read granted.
  - Any read grant -> starve_cnt cleared.
  - Read not valid -> starve_cnt cleared.
- Ready and valid:
  - r_req_ready=1 and w_req_ready=1 only in the cycle of the respective grant. Ready is 0 in INIT.
  - Requesters hold valid and payload until ready. A transfer occurs when valid and ready are both high.
- Read latency:
  - Read granted at cycle T -> r_resp_valid=1 at T+1, with r_resp_data = sram_rdata sampled at T+1.
  - r_resp_data is registered at T+1 and shown through a bypass mux, so it equals sram_rdata during the pulse and holds that value afterwards.
  - A later write to the same address does not change the held value.
- Throughput: back-to-back reads deliver one response per cycle.
- Read after write to the same address:
  - A write granted at T and a read granted at T+1 return the new data at T+2.
  - Masked-off lanes return their old contents.
- Address wrap: none; the full address range is legal and there is no bounds check.
- Reset mid-operation:
  - Any in-flight response is dropped; r_resp_valid=0 in the cycle after reset.
  - An INIT sweep restarts from address 0.

Optional Feature:
- Macro: SRAM_ARB_CTRL_INIT_EN.
- Defined:
  - INIT drives sram_en=1, sram_wmode=1, sram_wmask all ones, sram_wdata=0, with sram_addr counting 0..DEPTH-1, one write per cycle.
  - Both readies are 0 during INIT.
  - init_done rises exactly DEPTH cycles after reset deasserts, i.e. the cycle after the last sweep write, and stays 1 until the next reset.
- Not defined: no INIT state; init_done is tied to 1 and RUN begins immediately after reset.

Test Plan:
- Init sweep (macro defined): release reset -> sram_en=1 with addresses 0..1023 over 1024 cycles, init_done=1 at cycle 1024, then any read returns all-zero data.
- Write then read: write addr 0x155, mask 0xFFFF, data pattern A; then read 0x155 -> r_resp_valid one cycle after the read grant, r_resp_data=A, held after the pulse.
- Partial mask: write B to 0x3FF with mask 0x0001 over prior A -> lane 0 = B[131:0], lanes 1..15 = A.
- Contention: read and write valid continuously, STARVE_MAX=4 -> grant pattern W,W,W,W,R repeating; a read never waits more than 4 cycles.
- Reset mid-stream: assert reset in the cycle after a read grant -> no r_resp_valid pulse; with init enabled the sweep restarts at address 0.
- Back-to-back reads to 0x000, 0x001, 0x002 -> three consecutive r_resp_valid pulses carrying the matching data in order.
